alu_mc: RTL and testbench

Parametrised multi-cycle ALU for the pipelined and multi-cycle CPU datapaths. It keeps the existing 4-bit ALU control encoding and adds shifts, NOR, an iterative multiplier and an optional iterative divider. Operands are taken through a valid/ready handshake, and a registered result is returned through a second valid/ready handshake. It sits between the ID/EX operand registers and the EX/MEM stage, and stalls the pipeline through `in_ready_o`.

---
 rtl/alu_mc_if.sv | 26 ++
 rtl/alu_mc.sv | 180 ++++++++++++++++++
 tb/tb_alu_mc.sv | 173 +++++++++++++++++
 3 files changed

// File: rtl/alu_mc_if.sv
// alu_mc_if: operand and result handshake bundle for alu_mc.
// The ALU side uses the slave modport; the producer/consumer side uses master.
interface alu_mc_if #(
    parameter int unsigned WIDTH = 32
);
    logic             in_valid_i;
    logic             in_ready_o;
    logic [WIDTH-1:0] src1_i;
    logic [WIDTH-1:0] src2_i;
    logic [3:0]       ALU_control_i;
    logic             out_valid_o;
    logic             out_ready_i;
    logic [WIDTH-1:0] result_o;
    logic             zero_o;
    logic             err_o;

    modport slave (
        input  in_valid_i, src1_i, src2_i, ALU_control_i, out_ready_i,
        output in_ready_o, out_valid_o, result_o, zero_o, err_o
    );

    modport master (
        output in_valid_i, src1_i, src2_i, ALU_control_i, out_ready_i,
        input  in_ready_o, out_valid_o, result_o, zero_o, err_o
    );
endinterface

// File: rtl/alu_mc.sv
// alu_mc: multi-cycle ALU (shift-add multiplier, optional restoring divider) behind
// valid/ready handshakes. Define ALU_MC_DIV_EN to build the divider (ops 1010/1011).
module alu_mc #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = $clog2(WIDTH) + 1
) (
    input logic     clk_i,
    input logic     rst_i,
    alu_mc_if.slave bus
);
    localparam int unsigned ShW = $clog2(WIDTH);

    localparam logic [3:0] OpAnd = 4'b0000;
    localparam logic [3:0] OpOr  = 4'b0001;
    localparam logic [3:0] OpAdd = 4'b0010;
    localparam logic [3:0] OpSll = 4'b0011;
    localparam logic [3:0] OpSrl = 4'b0100;
    localparam logic [3:0] OpSra = 4'b0101;
    localparam logic [3:0] OpSub = 4'b0110;
    localparam logic [3:0] OpSlt = 4'b0111;
    localparam logic [3:0] OpMul = 4'b1000;
    localparam logic [3:0] OpNor = 4'b1100;
`ifdef ALU_MC_DIV_EN
    localparam logic [3:0] OpDiv = 4'b1010;
    localparam logic [3:0] OpRem = 4'b1011;
`endif

    typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

    state_e           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [3:0]       op_q, op_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    // acc: mul accumulator / div partial remainder; sh: multiplier / quotient;
    // md: multiplicand (shifts left) / divisor magnitude (constant)
    logic [WIDTH-1:0] acc_q, acc_d, sh_q, sh_d, md_q, md_d;
    logic [WIDTH-1:0] result_q, result_d;
    logic             err_q, err_d;

    logic [WIDTH-1:0] alu_res;
    logic             alu_err;
    logic [ShW-1:0]   shamt;
    logic             in_iter;

    assign shamt = b_q[ShW-1:0];

`ifdef ALU_MC_DIV_EN
    logic             in_div;
    logic             div_zero;
    logic [WIDTH:0]   trial;
    logic             trial_ge;

    assign in_iter  = bus.ALU_control_i inside {OpMul, OpDiv, OpRem};
    assign in_div   = bus.ALU_control_i inside {OpDiv, OpRem};
    assign div_zero = (b_q == '0);
    assign trial    = {acc_q, sh_q[WIDTH-1]};
    assign trial_ge = (trial >= {1'b0, md_q});
`else
    assign in_iter  = (bus.ALU_control_i == OpMul);
`endif

    // Final-cycle result from latched operands and iteration registers
    always_comb begin
        alu_res = '0;
        alu_err = 1'b0;
        case (op_q)
            OpAnd: alu_res = a_q & b_q;
            OpOr:  alu_res = a_q | b_q;
            OpNor: alu_res = ~(a_q | b_q);
            OpAdd: alu_res = a_q + b_q;
            OpSub: alu_res = a_q - b_q;
            OpSlt: alu_res = {{(WIDTH-1){1'b0}}, ($signed(a_q) < $signed(b_q))};
            OpSll: alu_res = a_q << shamt;
            OpSrl: alu_res = a_q >> shamt;
            OpSra: alu_res = $unsigned($signed(a_q) >>> shamt);
            OpMul: alu_res = acc_q;
`ifdef ALU_MC_DIV_EN
            OpDiv: begin
                alu_err = div_zero;
                alu_res = div_zero ? '1 : ((a_q[WIDTH-1] ^ b_q[WIDTH-1]) ? -sh_q : sh_q);
            end
            OpRem: begin
                alu_err = div_zero;
                alu_res = div_zero ? a_q : (a_q[WIDTH-1] ? -acc_q : acc_q);
            end
`endif
            default: alu_err = 1'b1;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        op_d     = op_q;
        a_d      = a_q;
        b_d      = b_q;
        acc_d    = acc_q;
        sh_d     = sh_q;
        md_d     = md_q;
        result_d = result_q;
        err_d    = err_q;
        unique case (state_q)
            StIdle: begin
                if (bus.in_valid_i) begin
                    op_d    = bus.ALU_control_i;
                    a_d     = bus.src1_i;
                    b_d     = bus.src2_i;
                    acc_d   = '0;
                    sh_d    = bus.src2_i;
                    md_d    = bus.src1_i;
                    // Single-cycle ops spend one BUSY cycle with the counter at 0
                    cnt_d   = in_iter ? CNT_W'(WIDTH) : '0;
                    state_d = StBusy;
`ifdef ALU_MC_DIV_EN
                    if (in_div) begin
                        sh_d = bus.src1_i[WIDTH-1] ? -bus.src1_i : bus.src1_i;
                        md_d = bus.src2_i[WIDTH-1] ? -bus.src2_i : bus.src2_i;
                    end
`endif
                end
            end
            StBusy: begin
                if (cnt_q == '0) begin
                    result_d = alu_res;
                    err_d    = alu_err;
                    state_d  = StDone;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (op_q == OpMul) begin
                        if (sh_q[0]) acc_d = acc_q + md_q;
                        md_d = md_q << 1;
                        sh_d = sh_q >> 1;
                    end
`ifdef ALU_MC_DIV_EN
                    else begin
                        acc_d = trial_ge ? (trial[WIDTH-1:0] - md_q) : trial[WIDTH-1:0];
                        sh_d  = {sh_q[WIDTH-2:0], trial_ge};
                    end
`endif
                end
            end
            StDone: begin
                if (bus.out_ready_i) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q  <= StIdle;
            cnt_q    <= '0;
            op_q     <= '0;
            a_q      <= '0;
            b_q      <= '0;
            acc_q    <= '0;
            sh_q     <= '0;
            md_q     <= '0;
            result_q <= '0;
            err_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            op_q     <= op_d;
            a_q      <= a_d;
            b_q      <= b_d;
            acc_q    <= acc_d;
            sh_q     <= sh_d;
            md_q     <= md_d;
            result_q <= result_d;
            err_q    <= err_d;
        end
    end

    assign bus.in_ready_o  = (state_q == StIdle);
    assign bus.out_valid_o = (state_q == StDone);
    assign bus.result_o    = result_q;
    assign bus.zero_o      = ~|result_q;
    assign bus.err_o       = err_q;
endmodule

// File: tb/tb_alu_mc.sv
// tb_alu_mc: directed self-checking bench for alu_mc at WIDTH=32.
module tb_alu_mc;
    localparam int unsigned W = 32;

    logic clk;
    logic rst;
    int   checks = 0;
    int   errors = 0;

    alu_mc_if #(.WIDTH(W)) bus ();

    alu_mc #(.WIDTH(W)) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        assert (got === exp)
        else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Present an op; returns 1ns after the accepting edge.
    task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
        bus.in_valid_i    = 1'b1;
        bus.ALU_control_i = op;
        bus.src1_i        = a;
        bus.src2_i        = b;
        @(posedge clk);
        #1;
        bus.in_valid_i    = 1'b0;
        bus.src1_i        = '0;
        bus.src2_i        = '0;
    endtask

    task automatic run_op(input string tag, input logic [3:0] op, input logic [W-1:0] a,
                          input logic [W-1:0] b, input int lat, input logic [W-1:0] exp_res,
                          input logic exp_err);
        logic early = 1'b0;
        issue(op, a, b);
        for (int i = 0; i < lat; i++) begin
            if (bus.out_valid_o !== 1'b0 || bus.in_ready_o !== 1'b0) early = 1'b1;
            @(posedge clk);
            #1;
        end
        check({tag, ".busy"}, {31'd0, early}, 32'd0);
        check({tag, ".valid"}, {31'd0, bus.out_valid_o}, 32'd1);
        check({tag, ".result"}, bus.result_o, exp_res);
        check({tag, ".err"}, {31'd0, bus.err_o}, {31'd0, exp_err});
        check({tag, ".zero"}, {31'd0, bus.zero_o}, {31'd0, (exp_res == '0)});
        @(posedge clk);
        #1;
        check({tag, ".idle"}, {30'd0, bus.in_ready_o, bus.out_valid_o}, 32'b10);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic           bad;
        logic [W-1:0]   held;

        rst               = 1'b1;
        bus.in_valid_i    = 1'b0;
        bus.out_ready_i   = 1'b1;
        bus.src1_i        = '0;
        bus.src2_i        = '0;
        bus.ALU_control_i = '0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        check("rst.in_ready", {31'd0, bus.in_ready_o}, 32'd1);
        check("rst.out_valid", {31'd0, bus.out_valid_o}, 32'd0);
        check("rst.result", bus.result_o, 32'd0);
        check("rst.zero", {31'd0, bus.zero_o}, 32'd1);
        check("rst.err", {31'd0, bus.err_o}, 32'd0);

        run_op("add_ovf", 4'b0010, 32'h7FFF_FFFF, 32'h1, 1, 32'h8000_0000, 1'b0);
        run_op("sub_zero", 4'b0110, 32'd5, 32'd5, 1, 32'h0, 1'b0);
        run_op("slt_true", 4'b0111, 32'hFFFF_FFFF, 32'd1, 1, 32'h1, 1'b0);
        run_op("slt_false", 4'b0111, 32'd1, 32'hFFFF_FFFF, 1, 32'h0, 1'b0);
        run_op("sra", 4'b0101, 32'h8000_0000, 32'd4, 1, 32'hF800_0000, 1'b0);
        run_op("srl", 4'b0100, 32'h8000_0000, 32'd4, 1, 32'h0800_0000, 1'b0);
        run_op("sll31", 4'b0011, 32'h1, 32'd31, 1, 32'h8000_0000, 1'b0);
        run_op("sll_amt", 4'b0011, 32'h1, 32'd35, 1, 32'h8, 1'b0);
        run_op("and", 4'b0000, 32'hF0F0_1234, 32'h0FF0_FF00, 1, 32'h00F0_1200, 1'b0);
        run_op("or", 4'b0001, 32'hF0F0_1234, 32'h0FF0_FF00, 1, 32'hFFF0_FF34, 1'b0);
        run_op("nor", 4'b1100, 32'hF0F0_0000, 32'h0000_000F, 1, 32'h0F0F_FFF0, 1'b0);
        run_op("illegal", 4'b1111, 32'd3, 32'd4, 1, 32'h0, 1'b1);

        run_op("mul_neg", 4'b1000, 32'hFFFF_FFFD, 32'd7, W + 1, 32'hFFFF_FFEB, 1'b0);
        run_op("mul_wrap", 4'b1000, 32'h0001_0000, 32'h0001_0000, W + 1, 32'h0, 1'b0);
        run_op("mul_ones", 4'b1000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, W + 1, 32'h1, 1'b0);

`ifdef ALU_MC_DIV_EN
        run_op("div_neg", 4'b1010, 32'hFFFF_FFF9, 32'd2, W + 1, 32'hFFFF_FFFD, 1'b0);
        run_op("rem_neg", 4'b1011, 32'hFFFF_FFF9, 32'd2, W + 1, 32'hFFFF_FFFF, 1'b0);
        run_op("div_pos", 4'b1010, 32'd100, 32'd7, W + 1, 32'd14, 1'b0);
        run_op("rem_pos", 4'b1011, 32'd100, 32'hFFFF_FFF9, W + 1, 32'd2, 1'b0);
        run_op("div_by0", 4'b1010, 32'd9, 32'd0, W + 1, 32'hFFFF_FFFF, 1'b1);
        run_op("rem_by0", 4'b1011, 32'd9, 32'd0, W + 1, 32'd9, 1'b1);
        run_op("div_minm1", 4'b1010, 32'h8000_0000, 32'hFFFF_FFFF, W + 1, 32'h8000_0000, 1'b0);
        run_op("rem_minm1", 4'b1011, 32'h8000_0000, 32'hFFFF_FFFF, W + 1, 32'h0, 1'b0);
`else
        run_op("div_off", 4'b1010, 32'd9, 32'd2, 1, 32'h0, 1'b1);
        run_op("rem_off", 4'b1011, 32'd9, 32'd2, 1, 32'h0, 1'b1);
`endif

        // Back-pressure: result held while out_ready is low, new ops ignored
        bus.out_ready_i = 1'b0;
        issue(4'b0010, 32'd3, 32'd4);
        @(posedge clk);
        #1;
        check("bp.valid", {31'd0, bus.out_valid_o}, 32'd1);
        check("bp.result", bus.result_o, 32'd7);
        held = bus.result_o;
        bad  = 1'b0;
        for (int i = 0; i < 10; i++) begin
            bus.in_valid_i    = 1'b1;
            bus.ALU_control_i = 4'b0110;
            bus.src1_i        = 32'd100 + 32'(i);
            bus.src2_i        = 32'd1;
            @(posedge clk);
            #1;
            if (bus.result_o !== held || bus.out_valid_o !== 1'b1 || bus.in_ready_o !== 1'b0)
                bad = 1'b1;
        end
        bus.in_valid_i = 1'b0;
        check("bp.hold", {31'd0, bad}, 32'd0);
        check("bp.result_after", bus.result_o, 32'd7);
        bus.out_ready_i = 1'b1;
        @(posedge clk);
        #1;
        check("bp.release", {30'd0, bus.in_ready_o, bus.out_valid_o}, 32'b10);
        @(posedge clk);
        #1;
        check("bp.no_accept", {30'd0, bus.in_ready_o, bus.out_valid_o}, 32'b10);

        // Reset five cycles into a multiply aborts it
        issue(4'b1000, 32'd5, 32'd6);
        repeat (5) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("abort.in_ready", {31'd0, bus.in_ready_o}, 32'd1);
        check("abort.out_valid", {31'd0, bus.out_valid_o}, 32'd0);
        check("abort.result", bus.result_o, 32'd0);
        check("abort.zero_err", {30'd0, bus.zero_o, bus.err_o}, 32'b10);
        bad = 1'b0;
        for (int i = 0; i < 40; i++) begin
            if (bus.out_valid_o !== 1'b0 || bus.in_ready_o !== 1'b1) bad = 1'b1;
            @(posedge clk);
            #1;
        end
        check("abort.quiet", {31'd0, bad}, 32'd0);
        run_op("after_abort", 4'b0010, 32'd1, 32'd1, 1, 32'd2, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
